// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM encoding for the BCD-to-binary decoder
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } bcd_state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_SUB    = 4'd3;

   // True when a nibble is not a legal decimal digit
   function automatic logic digit_invalid(input logic [3:0] d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - per-digit reverse double-dabble correction (d>=8 ? d-3 : d)
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // After a right shift a digit >= 8 carried in a weight-5 bit, so pull it back by 3
   always_comb begin
      dout = din;
      if (din >= ADJ_THRESH) begin
         dout = din - ADJ_SUB;
      end
   end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// rtl/bcd_to_bin_converter.sv - sequential multi-digit BCD-to-binary decoder (reverse double-dabble)
module bcd_to_bin_converter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14,
   parameter int CNT_W  = 4
)
(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BIN_W-1:0]      bin
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int WRK_W = BCD_W + BIN_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   bcd_state_t          state_q, state_d;
   logic [WRK_W-1:0]    wrk_q,   wrk_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;
   logic                err_q,   err_d;
   logic [BIN_W-1:0]    bin_q,   bin_d;

   logic [WRK_W-1:0]    shifted;
   logic [BCD_W-1:0]    adj_field;
   logic                bcd_bad;

   assign shifted = wrk_q >> 1;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : gen_adj
         bcd_digit_adj u_adj (
            .din  (shifted[BIN_W + 4*g +: 4]),
            .dout (adj_field[4*g +: 4])
         );
      end
   endgenerate

   // Flag any nibble of the incoming operand that is not a decimal digit
   always_comb begin
      bcd_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_invalid(bcd[4*i +: 4])) begin
            bcd_bad = 1'b1;
         end
      end
   end

   // Next-state and output-register logic; an invalid operand waits one FINISH
   // cycle with done low so its done pulse lands after the edge following the start
   always_comb begin
      state_d = state_q;
      wrk_d   = wrk_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      bin_d   = bin_q;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               wrk_d  = {bcd, {BIN_W{1'b0}}};
               cnt_d  = '0;
               busy_d = 1'b1;
               if (bcd_bad) begin
                  state_d = ST_FINISH;
                  err_d   = 1'b1;
                  bin_d   = '0;
               end else begin
                  state_d = ST_SHIFT;
                  err_d   = 1'b0;
               end
            end
         end
         ST_SHIFT: begin
            wrk_d = {adj_field, shifted[BIN_W-1:0]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               bin_d   = shifted[BIN_W-1:0];
               done_d  = 1'b1;
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            if (done_q) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; clearing mid-conversion abandons it with no done
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         wrk_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         wrk_q   <= wrk_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bin_q   <= bin_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign bin  = bin_q;

endmodule
